// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared constants and types for the ctrl_seq control
//                sequencer: opcode values, address-mux and shifter codes,
//                sequencer state encoding and the opcode-class decode record.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Opcodes (ir[IW-1:IW-4])
    localparam logic [3:0] c_OP_NOP  = 4'd0;
    localparam logic [3:0] c_OP_MOVA = 4'd1;
    localparam logic [3:0] c_OP_MOVB = 4'd2;
    localparam logic [3:0] c_OP_MOVC = 4'd3;
    localparam logic [3:0] c_OP_ADD  = 4'd4;
    localparam logic [3:0] c_OP_SUB  = 4'd5;
    localparam logic [3:0] c_OP_AND  = 4'd6;
    localparam logic [3:0] c_OP_NOT  = 4'd7;
    localparam logic [3:0] c_OP_RSR  = 4'd8;
    localparam logic [3:0] c_OP_RSL  = 4'd9;
    localparam logic [3:0] c_OP_JMP  = 4'd10;
    localparam logic [3:0] c_OP_JZ   = 4'd11;
    localparam logic [3:0] c_OP_JC   = 4'd12;
    localparam logic [3:0] c_OP_IN   = 4'd13;
    localparam logic [3:0] c_OP_OUT  = 4'd14;
    localparam logic [3:0] c_OP_HALT = 4'd15;

    // Memory address mux select
    localparam logic [1:0] c_MADD_PC = 2'b00;
    localparam logic [1:0] c_MADD_RA = 2'b01;
    localparam logic [1:0] c_MADD_WA = 2'b10;

    // Shifter select
    localparam logic [1:0] c_SHI_NONE  = 2'b00;
    localparam logic [1:0] c_SHI_PASS  = 2'b01;
    localparam logic [1:0] c_SHI_RIGHT = 2'b10;
    localparam logic [1:0] c_SHI_LEFT  = 2'b11;

    // Flag-update enables: bit 1 carry, bit 0 zero
    localparam logic [1:0] c_FLAG_NONE  = 2'b00;
    localparam logic [1:0] c_FLAG_CARRY = 2'b10;
    localparam logic [1:0] c_FLAG_BOTH  = 2'b11;

    // Sequencer state encoding
    localparam logic [1:0] c_ST_FETCH = 2'd0;
    localparam logic [1:0] c_ST_EXEC  = 2'd1;
    localparam logic [1:0] c_ST_HALT  = 2'd2;

    // Opcode class plus the static controls of single-cycle operations
    typedef struct packed {
        logic       single;   // completes in one EXEC cycle (nop, mova, add..rsl)
        logic       movb;     // register -> memory store
        logic       movc;     // memory -> register load
        logic       jump;     // jmp / jz / jc
        logic       cond_z;   // jump qualified by zero flag
        logic       cond_c;   // jump qualified by carry flag
        logic       is_in;
        logic       is_out;
        logic       is_halt;
        logic       reg_we;   // single-cycle register write
        logic       alu_m;    // single-cycle arithmetic mode
        logic [1:0] shi_sel;  // single-cycle shifter select
        logic [1:0] flag_en;  // single-cycle flag updates
    } decode_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Combinational opcode-to-class decode for ctrl_seq.
//  Ports       : opcode (in, 4)        - instruction opcode field
//                dec    (out, decode_t) - opcode class and static controls
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output decode_t    dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            c_OP_NOP: begin
                dec.single = 1'b1;
            end
            c_OP_MOVA: begin
                dec.single  = 1'b1;
                dec.reg_we  = 1'b1;
                dec.shi_sel = c_SHI_PASS;
            end
            c_OP_MOVB: dec.movb = 1'b1;
            c_OP_MOVC: dec.movc = 1'b1;
            c_OP_ADD, c_OP_SUB: begin
                dec.single  = 1'b1;
                dec.reg_we  = 1'b1;
                dec.alu_m   = 1'b1;
                dec.shi_sel = c_SHI_PASS;
                dec.flag_en = c_FLAG_BOTH;
            end
            c_OP_AND, c_OP_NOT: begin
                dec.single  = 1'b1;
                dec.reg_we  = 1'b1;
                dec.alu_m   = 1'b1;
                dec.shi_sel = c_SHI_PASS;
                dec.flag_en = c_FLAG_NONE;
            end
            c_OP_RSR, c_OP_RSL: begin
                dec.single  = 1'b1;
                dec.reg_we  = 1'b1;
                dec.alu_m   = 1'b1;
                dec.shi_sel = (opcode == c_OP_RSR) ? c_SHI_RIGHT : c_SHI_LEFT;
                dec.flag_en = c_FLAG_CARRY;
            end
            c_OP_JMP: dec.jump = 1'b1;
            c_OP_JZ: begin
                dec.jump   = 1'b1;
                dec.cond_z = 1'b1;
            end
            c_OP_JC: begin
                dec.jump   = 1'b1;
                dec.cond_c = 1'b1;
            end
            c_OP_IN:   dec.is_in   = 1'b1;
            c_OP_OUT:  dec.is_out  = 1'b1;
            c_OP_HALT: dec.is_halt = 1'b1;
            default: dec.shi_sel = c_SHI_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_seq
//  Description : FETCH / EXEC / HALT control sequencer for a small
//                accumulator-style datapath. All outputs are combinational
//                from state, ir, flags and handshake inputs.
//  Ports       : clk, rst (sync, active-high)
//                ir[IW], z, c, mem_ready, in_valid, out_ready   (inputs)
//                reg_ra, reg_wa, madd, alu_s, alu_m, shi_sel, reg_we,
//                ram_xl, ram_dl, pc_ld, pc_inc, ir_ld, flag_en, in_en,
//                out_en, halted                                 (outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int IW  = 8,
    parameter int RAW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IW-1:0]  ir,
    input  logic           z,
    input  logic           c,
    input  logic           mem_ready,
    input  logic           in_valid,
    input  logic           out_ready,
    output logic [RAW-1:0] reg_ra,
    output logic [RAW-1:0] reg_wa,
    output logic [1:0]     madd,
    output logic [3:0]     alu_s,
    output logic           alu_m,
    output logic [1:0]     shi_sel,
    output logic           reg_we,
    output logic           ram_xl,
    output logic           ram_dl,
    output logic           pc_ld,
    output logic           pc_inc,
    output logic           ir_ld,
    output logic [1:0]     flag_en,
    output logic           in_en,
    output logic           out_en,
    output logic           halted
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] w_opcode;
    logic       w_taken;
    logic       w_unused_ir;
    decode_t    w_dec;

    assign w_opcode    = ir[IW-1:IW-4];
    // Bits between the register fields and the opcode carry no control meaning.
    assign w_unused_ir = ^ir;

    ctrl_decode u_decode (
        .opcode (w_opcode),
        .dec    (w_dec)
    );

    // Field decode is visible in every state, including reset.
    assign reg_ra = ir[RAW-1:0];
    assign reg_wa = ir[2*RAW-1:RAW];
    assign alu_s  = w_opcode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        madd        = c_MADD_PC;
        alu_m       = 1'b0;
        shi_sel     = c_SHI_NONE;
        reg_we      = 1'b0;
        ram_xl      = 1'b0;
        ram_dl      = 1'b0;
        pc_ld       = 1'b0;
        pc_inc      = 1'b0;
        ir_ld       = 1'b0;
        flag_en     = c_FLAG_NONE;
        in_en       = 1'b0;
        out_en      = 1'b0;
        halted      = 1'b0;
        // Unconditional jmp has neither qualifier set.
        w_taken     = w_dec.jump & ((~w_dec.cond_z & ~w_dec.cond_c) |
                                    (w_dec.cond_z & z) | (w_dec.cond_c & c));

        // Reset gates every strobe so an access in flight is dropped
        // in the very cycle rst is seen, whatever the current state.
        if (!rst) begin
            case (r_state)
                c_ST_FETCH: begin
                    ram_dl = 1'b1;
                    if (mem_ready) begin
                        ir_ld       = 1'b1;
                        pc_inc      = 1'b1;
                        w_state_nxt = c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    if (w_dec.single) begin
                        reg_we      = w_dec.reg_we;
                        alu_m       = w_dec.alu_m;
                        shi_sel     = w_dec.shi_sel;
                        flag_en     = w_dec.flag_en;
                        w_state_nxt = c_ST_FETCH;
                    end else if (w_dec.movb) begin
                        madd    = c_MADD_WA;
                        ram_xl  = 1'b1;
                        shi_sel = c_SHI_PASS;
                        if (mem_ready) w_state_nxt = c_ST_FETCH;
                    end else if (w_dec.movc) begin
                        madd   = c_MADD_RA;
                        ram_dl = 1'b1;
                        reg_we = 1'b1;
                        if (mem_ready) w_state_nxt = c_ST_FETCH;
                    end else if (w_dec.jump) begin
                        if (w_taken) begin
                            madd   = c_MADD_PC;
                            ram_dl = 1'b1;
                            pc_ld  = mem_ready;
                            if (mem_ready) w_state_nxt = c_ST_FETCH;
                        end else begin
                            // Skip over the target word that follows the jump.
                            pc_inc      = 1'b1;
                            w_state_nxt = c_ST_FETCH;
                        end
                    end else if (w_dec.is_in) begin
                        in_en  = in_valid;
                        reg_we = in_valid;
                        if (in_valid) w_state_nxt = c_ST_FETCH;
                    end else if (w_dec.is_out) begin
                        out_en  = 1'b1;
                        alu_m   = 1'b1;
                        shi_sel = c_SHI_PASS;
                        if (out_ready) w_state_nxt = c_ST_FETCH;
                    end else begin
                        w_state_nxt = c_ST_HALT;
                    end
                end
                c_ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    w_state_nxt = c_ST_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_seq
//  Description : Self-checking bench for ctrl_seq: directed cycle table,
//                multi-cycle handshake sequences and a randomized run
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq;

    typedef struct packed {
        logic [1:0] madd;
        logic [3:0] alu_s;
        logic       alu_m;
        logic [1:0] shi_sel;
        logic       reg_we;
        logic       ram_xl;
        logic       ram_dl;
        logic       pc_ld;
        logic       pc_inc;
        logic       ir_ld;
        logic [1:0] flag_en;
        logic       in_en;
        logic       out_en;
        logic       halted;
        logic [1:0] reg_ra;
        logic [1:0] reg_wa;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic [7:0] ir;
        logic       z;
        logic       c;
        logic       mr;
        logic       iv;
        logic       ordy;
        outs_t      exp;
    } vec_t;

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_HALT  = 2;
    localparam int NVEC     = 19;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir;
    logic       z, c, mem_ready, in_valid, out_ready;
    logic [1:0] reg_ra, reg_wa, madd, shi_sel, flag_en;
    logic [3:0] alu_s;
    logic       alu_m, reg_we, ram_xl, ram_dl, pc_ld, pc_inc, ir_ld;
    logic       in_en, out_en, halted;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ctrl_seq #(.IW(8), .RAW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .z         (z),
        .c         (c),
        .mem_ready (mem_ready),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .reg_ra    (reg_ra),
        .reg_wa    (reg_wa),
        .madd      (madd),
        .alu_s     (alu_s),
        .alu_m     (alu_m),
        .shi_sel   (shi_sel),
        .reg_we    (reg_we),
        .ram_xl    (ram_xl),
        .ram_dl    (ram_dl),
        .pc_ld     (pc_ld),
        .pc_inc    (pc_inc),
        .ir_ld     (ir_ld),
        .flag_en   (flag_en),
        .in_en     (in_en),
        .out_en    (out_en),
        .halted    (halted)
    );

    // Build an expected output record; field decode comes from the instruction.
    function automatic outs_t e(input logic [7:0] i, input logic [1:0] md,
                                input logic am, input logic [1:0] sh,
                                input logic we, input logic xl, input logic dl,
                                input logic pl, input logic inc, input logic irl,
                                input logic [1:0] fe, input logic ien,
                                input logic oen, input logic h);
        outs_t o;
        o.madd = md;  o.alu_s = i[7:4]; o.alu_m = am; o.shi_sel = sh;
        o.reg_we = we; o.ram_xl = xl; o.ram_dl = dl; o.pc_ld = pl;
        o.pc_inc = inc; o.ir_ld = irl; o.flag_en = fe; o.in_en = ien;
        o.out_en = oen; o.halted = h; o.reg_ra = i[1:0]; o.reg_wa = i[3:2];
        return o;
    endfunction

    function automatic vec_t mkv(input logic r, input logic [7:0] i,
                                 input logic zz, input logic cc, input logic mr,
                                 input logic iv, input logic ordy, input outs_t x);
        vec_t v;
        v.rst = r; v.ir = i; v.z = zz; v.c = cc; v.mr = mr;
        v.iv = iv; v.ordy = ordy; v.exp = x;
        return v;
    endfunction

    // Reference model: what the instruction set says each cycle must do.
    function automatic outs_t model_out(input int ph, input logic r,
                                        input logic [7:0] i, input logic zz,
                                        input logic cc, input logic mr,
                                        input logic iv);
        int    op;
        bit    taken;
        outs_t o;
        o = e(i, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
        op = int'(i[7:4]);
        if (r) return o;
        if (ph == PH_FETCH) begin
            o.ram_dl = 1;
            o.ir_ld  = mr;
            o.pc_inc = mr;
        end else if (ph == PH_HALT) begin
            o.halted = 1;
        end else begin
            if (op <= 1 || (op >= 4 && op <= 9)) begin
                o.reg_we  = (op != 0);
                o.alu_m   = (op >= 4);
                o.shi_sel = (op == 0) ? 2'd0 : (op == 8) ? 2'd2 : (op == 9) ? 2'd3 : 2'd1;
                o.flag_en = (op == 4 || op == 5) ? 2'd3 : (op >= 8) ? 2'd2 : 2'd0;
            end else if (op == 2) begin
                o.madd = 2'd2; o.ram_xl = 1; o.shi_sel = 2'd1;
            end else if (op == 3) begin
                o.madd = 2'd1; o.ram_dl = 1; o.reg_we = 1;
            end else if (op >= 10 && op <= 12) begin
                taken = (op == 10) || (op == 11 && zz) || (op == 12 && cc);
                if (taken) begin
                    o.ram_dl = 1; o.pc_ld = mr;
                end else begin
                    o.pc_inc = 1;
                end
            end else if (op == 13) begin
                o.in_en = iv; o.reg_we = iv;
            end else if (op == 14) begin
                o.out_en = 1; o.alu_m = 1; o.shi_sel = 2'd1;
            end
        end
        return o;
    endfunction

    function automatic int model_next(input int ph, input logic r,
                                      input logic [7:0] i, input logic zz,
                                      input logic cc, input logic mr,
                                      input logic iv, input logic ordy);
        int op;
        bit waits_mem;
        op = int'(i[7:4]);
        if (r) return PH_FETCH;
        if (ph == PH_FETCH) return mr ? PH_EXEC : PH_FETCH;
        if (ph == PH_HALT) return PH_HALT;
        if (op == 15) return PH_HALT;
        waits_mem = (op == 2) || (op == 3) || (op == 10) ||
                    (op == 11 && zz) || (op == 12 && cc);
        if (waits_mem) return mr ? PH_FETCH : PH_EXEC;
        if (op == 13) return iv ? PH_FETCH : PH_EXEC;
        if (op == 14) return ordy ? PH_FETCH : PH_EXEC;
        return PH_FETCH;
    endfunction

    // Drive inputs just after a rising edge, check mid-cycle, advance a cycle.
    task automatic step(input logic r, input logic [7:0] i, input logic zz,
                        input logic cc, input logic mr, input logic iv,
                        input logic ordy, input outs_t x, input string name);
        outs_t act;
        rst = r; ir = i; z = zz; c = cc;
        mem_ready = mr; in_valid = iv; out_ready = ordy;
        @(negedge clk);
        act = {madd, alu_s, alu_m, shi_sel, reg_we, ram_xl, ram_dl, pc_ld,
               pc_inc, ir_ld, flag_en, in_en, out_en, halted, reg_ra, reg_wa};
        tests++;
        if (act !== x) begin
            fails++;
            $display("FAIL %s t=%0t ir=%h: got %b want %b", name, $time, i, act, x);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [NVEC];

    initial begin
        int ph, nph;
        logic r, zz, cc, mr, iv, ordy;
        logic [7:0] i;
        outs_t x;

        // Directed cycle-by-cycle table (one row per clock).
        tbl[0]  = mkv(1, 8'h4B, 0, 0, 1, 0, 0, e(8'h4B, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[1]  = mkv(0, 8'h4B, 0, 0, 1, 0, 0, e(8'h4B, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl[2]  = mkv(0, 8'h4B, 0, 0, 1, 0, 0, e(8'h4B, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        tbl[3]  = mkv(0, 8'hB0, 0, 0, 1, 0, 0, e(8'hB0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl[4]  = mkv(0, 8'hB0, 0, 0, 0, 0, 0, e(8'hB0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl[5]  = mkv(0, 8'hB0, 0, 0, 1, 0, 0, e(8'hB0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl[6]  = mkv(0, 8'hB0, 1, 0, 0, 0, 0, e(8'hB0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl[7]  = mkv(0, 8'hB0, 1, 0, 1, 0, 0, e(8'hB0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl[8]  = mkv(0, 8'hB0, 0, 0, 0, 0, 0, e(8'hB0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl[9]  = mkv(0, 8'hC0, 0, 0, 1, 0, 0, e(8'hC0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl[10] = mkv(0, 8'hC0, 1, 0, 1, 0, 0, e(8'hC0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl[11] = mkv(0, 8'h86, 0, 0, 1, 0, 0, e(8'h86, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl[12] = mkv(0, 8'h86, 0, 0, 0, 0, 0, e(8'h86, 0, 1, 2, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl[13] = mkv(0, 8'hD1, 0, 0, 1, 0, 0, e(8'hD1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl[14] = mkv(0, 8'hD1, 0, 0, 0, 0, 0, e(8'hD1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[15] = mkv(0, 8'hD1, 0, 0, 0, 1, 0, e(8'hD1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl[16] = mkv(0, 8'hA5, 0, 0, 1, 0, 0, e(8'hA5, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl[17] = mkv(0, 8'hA5, 0, 0, 0, 0, 0, e(8'hA5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl[18] = mkv(0, 8'hA5, 0, 0, 1, 0, 0, e(8'hA5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

        rst = 1; ir = 0; z = 0; c = 0; mem_ready = 0; in_valid = 0; out_ready = 0;
        @(posedge clk);
        #1;

        for (int k = 0; k < NVEC; k++) begin
            step(tbl[k].rst, tbl[k].ir, tbl[k].z, tbl[k].c, tbl[k].mr,
                 tbl[k].iv, tbl[k].ordy, tbl[k].exp, $sformatf("table[%0d]", k));
        end

        // movc with three wait cycles: access held, completes on 4th EXEC cycle.
        step(0, 8'h36, 0, 0, 1, 0, 0, e(8'h36, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), "movc_fetch");
        for (int k = 0; k < 4; k++) begin
            step(0, 8'h36, 0, 0, (k == 3), 0, 0,
                 e(8'h36, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), $sformatf("movc_exec%0d", k));
        end
        step(0, 8'h36, 0, 0, 0, 0, 0, e(8'h36, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "movc_back_fetch");

        // out with out_ready low for two cycles.
        step(0, 8'hE0, 0, 0, 1, 0, 0, e(8'hE0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), "out_fetch");
        for (int k = 0; k < 3; k++) begin
            step(0, 8'hE0, 0, 0, 0, 0, (k == 2),
                 e(8'hE0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), $sformatf("out_exec%0d", k));
        end
        step(0, 8'hE0, 0, 0, 0, 0, 0, e(8'hE0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "out_back_fetch");

        // Reset in the middle of a movb wait drops the store immediately.
        step(0, 8'h25, 0, 0, 1, 0, 0, e(8'h25, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), "movb_fetch");
        step(0, 8'h25, 0, 0, 0, 0, 0, e(8'h25, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "movb_wait");
        step(1, 8'h25, 0, 0, 0, 0, 0, e(8'h25, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "movb_rst");
        step(0, 8'h25, 0, 0, 0, 0, 0, e(8'h25, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "movb_post_rst");

        // halt: sticky for 10 cycles with every handshake high, then rst.
        step(0, 8'hF0, 0, 0, 1, 0, 0, e(8'hF0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), "halt_fetch");
        step(0, 8'hF0, 1, 1, 1, 1, 1, e(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_exec");
        for (int k = 0; k < 10; k++) begin
            step(0, 8'hF0, 1, 1, 1, 1, 1,
                 e(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("halted%0d", k));
        end
        step(1, 8'hF0, 1, 1, 1, 1, 1, e(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_rst");
        step(0, 8'hF0, 0, 0, 0, 0, 0, e(8'hF0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "halt_resume");

        // Randomized run against the reference model; starts from a reset cycle.
        ph = PH_FETCH;
        for (int k = 0; k < 1500; k++) begin
            r    = (k == 0) || ($urandom_range(0, 63) == 0);
            i    = 8'($urandom);
            zz   = 1'($urandom);
            cc   = 1'($urandom);
            mr   = 1'($urandom);
            iv   = 1'($urandom);
            ordy = 1'($urandom);
            x    = model_out(ph, r, i, zz, cc, mr, iv);
            nph  = model_next(ph, r, i, zz, cc, mr, iv, ordy);
            step(r, i, zz, cc, mr, iv, ordy, x, $sformatf("rand%0d", k));
            ph = nph;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
